// File: rtl/ncl_sample_sink.sv
// ncl_sample_sink: clocked receiver for an 8-bit dual-rail NCL sample stream.
// Synchronizes the rails, detects stable DATA/NULL wavefronts, drives the
// 4-phase acknowledge, queues captured words in a small FIFO with
// valid/ready output and checks that the stream is an incrementing count.
module ncl_sample_sink #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_t,
  input  logic [WIDTH-1:0] in_f,
  output logic             ackout,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  input  logic             seq_check_en,
  input  logic             err_clr,
  output logic             err_illegal,
  output logic             err_seq,
  output logic [15:0]      word_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_INIT      = 2'd0,
    ST_WAIT_DATA = 2'd1,
    ST_WAIT_NULL = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Rail synchronizers, sample history and priming
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]       t_sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]       f_sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]       p_t_q;
  logic [WIDTH-1:0]       p_f_q;
  logic [SYNC_STAGES-1:0] prime_q;

  logic [WIDTH-1:0] s_t;
  logic [WIDTH-1:0] s_f;

  assign s_t = t_sync_q[SYNC_STAGES-1];
  assign s_f = f_sync_q[SYNC_STAGES-1];

  // Multi-flop synchronizer chain for every rail.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        t_sync_q[i] <= '0;
        f_sync_q[i] <= '0;
      end
    end else begin
      t_sync_q[0] <= in_t;
      f_sync_q[0] <= in_f;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        t_sync_q[i] <= t_sync_q[i-1];
        f_sync_q[i] <= f_sync_q[i-1];
      end
    end
  end

  // Previous synchronized sample (P) and a flag that the synchronizer output
  // now holds a genuine rail sample rather than its cleared reset value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_t_q   <= '0;
      p_f_q   <= '0;
      prime_q <= '0;
    end else begin
      p_t_q   <= s_t;
      p_f_q   <= s_f;
      prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // ---------------------------------------------------------------------------
  // Wavefront classification
  // ---------------------------------------------------------------------------
  logic primed;
  logic s_complete;
  logic s_null;
  logic p_null;
  logic s_illegal;
  logic stable_data;
  logic stable_null;

  assign primed      = prime_q[SYNC_STAGES-1];
  assign s_complete  = &(s_t ^ s_f);
  assign s_null      = ~|(s_t | s_f);
  assign p_null      = ~|(p_t_q | p_f_q);
  assign s_illegal   = |(s_t & s_f);
  assign stable_data = primed && s_complete && (s_t == p_t_q) && (s_f == p_f_q);
  assign stable_null = primed && s_null && p_null;

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  state_e           state_q;
  state_e           state_d;
  logic             ackout_q;
  logic             accept;
  logic             can_accept;
  logic             pop;
  logic             push_q;
  logic [WIDTH-1:0] push_data_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] occ;
  logic             dout_valid_q;

  assign pop = dout_valid_q && dout_ready;
  // Committed occupancy includes the word still waiting in the push stage.
  assign occ        = cnt_q + CNT_W'(push_q);
  assign can_accept = (occ != CNT_W'(DEPTH)) || pop;

  // Next-state decode: capture stable DATA when room exists, return on stable NULL.
  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (stable_null) state_d = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        if (stable_data && can_accept) begin
          accept  = 1'b1;
          state_d = ST_WAIT_NULL;
        end
      end
      ST_WAIT_NULL: begin
        if (stable_null) state_d = ST_WAIT_DATA;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // State register; the acknowledge is a registered decode of the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_INIT;
      ackout_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ackout_q <= (state_d == ST_WAIT_DATA);
    end
  end

  // Push stage: the captured word enters the FIFO one edge after acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      push_q <= accept;
      if (accept) push_data_q <= s_t;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequence check, error flags and word counter
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] last_q;
  logic             have_last_q;
  logic             err_illegal_q;
  logic             err_seq_q;
  logic [15:0]      word_cnt_q;
  logic             seq_mismatch;

  assign seq_mismatch = seq_check_en && have_last_q && (s_t != '0) &&
                        (s_t != last_q + WIDTH'(1));

  // Sticky error flags and sequence history; the clear wins over any set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_illegal_q <= 1'b0;
      err_seq_q     <= 1'b0;
      last_q        <= '0;
      have_last_q   <= 1'b0;
    end else if (err_clr) begin
      err_illegal_q <= 1'b0;
      err_seq_q     <= 1'b0;
      last_q        <= '0;
      have_last_q   <= 1'b0;
    end else begin
      if (s_illegal) err_illegal_q <= 1'b1;
      if (accept) begin
        if (seq_mismatch) err_seq_q <= 1'b1;
        last_q      <= s_t;
        have_last_q <= 1'b1;
      end
    end
  end

  // Saturating count of accepted words.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_cnt_q <= '0;
    end else if (accept && (word_cnt_q != 16'hFFFF)) begin
      word_cnt_q <= word_cnt_q + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO with registered head
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [CNT_W-1:0] cnt_d;
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] dout_d;

  // Next read pointer, occupancy and head word (bypassing a same-cycle write).
  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    cnt_d    = cnt_q + CNT_W'(push_q) - CNT_W'(pop);
    dout_d   = dout_q;
    if (cnt_d != '0) begin
      if (push_q && (wr_ptr_q == rd_ptr_d)) dout_d = push_data_q;
      else                                  dout_d = mem_q[rd_ptr_d];
    end
  end

  // Storage array written from the push stage.
  // NOTE: the array has no reset; occupancy and pointers alone decide which
  // entries are meaningful, so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push_q) mem_q[wr_ptr_q] <= push_data_q;
  end

  // FIFO pointers, occupancy and the registered head/valid outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      if (push_q) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= (cnt_d != '0);
    end
  end

  assign ackout      = ackout_q;
  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign err_illegal = err_illegal_q;
  assign err_seq     = err_seq_q;
  assign word_cnt    = word_cnt_q;

endmodule

// File: tb/tb_ncl_sample_sink.sv
// Self-checking bench for ncl_sample_sink: a table of handshake words plus
// hand-written backpressure, illegal-rail, ripple and mid-transfer reset
// sequences. Delivered words are checked against a scoreboard queue.
module tb_ncl_sample_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_t;
  logic [7:0]  in_f;
  logic        ackout;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        seq_check_en;
  logic        err_clr;
  logic        err_illegal;
  logic        err_seq;
  logic [15:0] word_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;
  int lat;

  logic [7:0] sb_q [$];
  logic [7:0] tgt;

  typedef struct {
    logic       clr;
    logic [7:0] word;
    logic       exp_seq;
  } vec_t;

  vec_t vecs [7];

  ncl_sample_sink #(.WIDTH(8), .DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_t         (in_t),
    .in_f         (in_f),
    .ackout       (ackout),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .seq_check_en (seq_check_en),
    .err_clr      (err_clr),
    .err_illegal  (err_illegal),
    .err_seq      (err_seq),
    .word_cnt     (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic lvl, output int n);
    n = 0;
    while ((ackout !== lvl) && (n < 60)) begin
      step();
      n++;
    end
    if (ackout !== lvl) check("ack_timeout", 32'(ackout), 32'(lvl));
  endtask

  // Full 4-phase transfer of one word; exp_lat > 0 also checks edge latency.
  task automatic send_word(input logic [7:0] w, input int exp_lat);
    int n;
    in_t = w;
    in_f = ~w;
    wait_ack(1'b0, n);
    if (exp_lat > 0) check("data_latency", 32'(n), 32'(exp_lat));
    in_t = '0;
    in_f = '0;
    wait_ack(1'b1, n);
    if (exp_lat > 0) check("null_latency", 32'(n), 32'(exp_lat));
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  // Scoreboard: every word the consumer takes must match the queue head.
  always @(negedge clk) begin
    if (reset && dout_valid && dout_ready) begin
      if (sb_q.size() == 0) check("sb_underflow", 32'(dout), 32'hFFFF_FFFF);
      else                  check("dout", 32'(dout), 32'(sb_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{clr: 1'b0, word: 8'h00, exp_seq: 1'b0};
    vecs[1] = '{clr: 1'b0, word: 8'h01, exp_seq: 1'b0};
    vecs[2] = '{clr: 1'b0, word: 8'h02, exp_seq: 1'b0};
    vecs[3] = '{clr: 1'b1, word: 8'hFE, exp_seq: 1'b0};
    vecs[4] = '{clr: 1'b0, word: 8'hFF, exp_seq: 1'b0};
    vecs[5] = '{clr: 1'b0, word: 8'h00, exp_seq: 1'b0};
    vecs[6] = '{clr: 1'b0, word: 8'h05, exp_seq: 1'b1};

    reset        = 1'b0;
    in_t         = '0;
    in_f         = '0;
    dout_ready   = 1'b1;
    seq_check_en = 1'b1;
    err_clr      = 1'b0;

    // Reset state
    repeat (3) step();
    check("rst_ackout", 32'(ackout), 0);
    check("rst_valid", 32'(dout_valid), 0);
    check("rst_dout", 32'(dout), 0);
    check("rst_err_illegal", 32'(err_illegal), 0);
    check("rst_err_seq", 32'(err_seq), 0);
    check("rst_word_cnt", 32'(word_cnt), 0);

    // Release with NULL rails: acknowledge rises on the third edge
    @(negedge clk);
    reset = 1'b1;
    step();
    check("ack_edge1", 32'(ackout), 0);
    step();
    check("ack_edge2", 32'(ackout), 0);
    step();
    check("ack_edge3", 32'(ackout), 1);
    check("init_valid", 32'(dout_valid), 0);

    // Table: handshakes, sequence boundaries and mismatch
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].clr) begin
        pulse_clr();
        check("clr_err_seq", 32'(err_seq), 0);
      end
      sb_q.push_back(vecs[i].word);
      in_t = vecs[i].word;
      in_f = ~vecs[i].word;
      wait_ack(1'b0, lat);
      check("vec_data_latency", 32'(lat), 4);
      check("vec_err_seq", 32'(err_seq), 32'(vecs[i].exp_seq));
      exp_cnt++;
      check("vec_word_cnt", 32'(word_cnt), 32'(exp_cnt));
      in_t = '0;
      in_f = '0;
      wait_ack(1'b1, lat);
      check("vec_null_latency", 32'(lat), 4);
    end
    pulse_clr();
    check("err_seq_cleared", 32'(err_seq), 0);
    repeat (4) step();
    check("drained", 32'(dout_valid), 0);
    check("sb_drained", 32'(sb_q.size()), 0);

    // Backpressure: DEPTH words queue, the next one stalls until a pop
    seq_check_en = 1'b0;
    dout_ready   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(8'h10 + 8'(i));
      send_word(8'h10 + 8'(i), 4);
      exp_cnt++;
    end
    sb_q.push_back(8'h14);
    in_t = 8'h14;
    in_f = ~8'h14;
    repeat (10) step();
    check("bp_ack_held", 32'(ackout), 1);
    check("bp_head", 32'(dout), 32'h10);
    check("bp_word_cnt", 32'(word_cnt), 32'(exp_cnt));
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
    check("bp_ack_fall", 32'(ackout), 0);
    exp_cnt++;
    check("bp_word_cnt2", 32'(word_cnt), 32'(exp_cnt));
    in_t = '0;
    in_f = '0;
    wait_ack(1'b1, lat);
    dout_ready = 1'b1;
    repeat (8) step();
    check("bp_drained", 32'(sb_q.size()), 0);

    // Both rails of bit 3 high: flagged, never captured
    in_t = 8'h5A;
    in_f = 8'hA5 | 8'h08;
    repeat (8) step();
    check("ill_flag", 32'(err_illegal), 1);
    check("ill_ack", 32'(ackout), 1);
    check("ill_word_cnt", 32'(word_cnt), 32'(exp_cnt));
    in_t = '0;
    in_f = '0;
    repeat (5) step();
    pulse_clr();
    check("ill_cleared", 32'(err_illegal), 0);

    // Ripple bit-by-bit toward 0xA5: exactly one push
    tgt = 8'hA5;
    sb_q.push_back(tgt);
    for (int i = 0; i < 8; i++) begin
      in_t[i] = tgt[i];
      in_f[i] = ~tgt[i];
      repeat (1 + (i % 2)) step();
    end
    wait_ack(1'b0, lat);
    repeat (6) step();
    in_t = '0;
    in_f = '0;
    wait_ack(1'b1, lat);
    exp_cnt++;
    repeat (4) step();
    check("ripple_word_cnt", 32'(word_cnt), 32'(exp_cnt));
    check("ripple_sb", 32'(sb_q.size()), 0);
    check("ripple_no_err", 32'(err_illegal), 0);

    // Reset during WAIT_NULL with two words queued
    dout_ready = 1'b0;
    send_word(8'h30, 4);
    in_t = 8'h31;
    in_f = ~8'h31;
    wait_ack(1'b0, lat);
    step();
    check("pre_rst_valid", 32'(dout_valid), 1);
    #1;
    reset = 1'b0;
    #1;
    check("arst_ackout", 32'(ackout), 0);
    check("arst_valid", 32'(dout_valid), 0);
    check("arst_word_cnt", 32'(word_cnt), 0);
    in_t = '0;
    in_f = '0;
    dout_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    reset = 1'b1;
    wait_ack(1'b1, lat);
    check("post_rst_ack", 32'(ackout), 1);
    check("post_rst_valid", 32'(dout_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
